keypad_encoder: RTL and testbench

//   Transmit side of the door-lock key path. Takes the four raw keypad buttons (digits 1..4)
//   and synchronises and debounces them. Each clean press becomes a single 2-bit key code,

---
 rtl/keypad_encoder.sv | 124 ++++++++++++
 tb/tb_keypad_encoder.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_encoder.sv
// Keypad encoder: sync, debounce and queue digit presses 1..4 as 2-bit codes.
// Ports: clk, reset (async, active-high), key_raw[3:0] in; key_held[3:0] out;
//        key_code[1:0], key_valid out; key_ready in; dropped out.
module keypad_encoder #(
  parameter int DEBOUNCE_CYCLES = 20,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] key_raw,
  output logic [3:0] key_held,
  output logic [1:0] key_code,
  output logic       key_valid,
  input  logic       key_ready,
  output logic       dropped
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYCLES);
  localparam logic [AW:0] FULL = (AW+1)'(FIFO_DEPTH);

  logic [3:0] s1;
  logic [3:0] s2;
  logic [3:0] stable;
  logic [3:0] flip;
  logic [3:0] evt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= key_raw;
      s2 <= s1;
    end
  end

  for (genvar i = 0; i < 4; i++) begin : g_db
    logic          st;
    logic [CW-1:0] c;

    // The counter must hold DEBOUNCE_CYCLES before the level is allowed to flip.
    assign flip[i]   = (s2[i] != st) && (c == CMAX);
    assign stable[i] = st;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        c  <= '0;
        st <= 1'b0;
      end else if (s2[i] == st) begin
        c <= '0;
      end else if (flip[i]) begin
        c  <= '0;
        st <= ~st;
      end else begin
        c <= c + CW'(1);
      end
    end
  end

  assign key_held = stable;

  // A press is recorded on the same edge the stable level rises.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) evt <= '0;
    else       evt <= flip & ~stable;
  end

  logic       push;
  logic       multi;
  logic [1:0] sel;

  always_comb begin
    push  = |evt;
    multi = |(evt & (evt - 4'd1));
    sel   = 2'd0;
    priority case (1'b1)
      evt[0]:  sel = 2'd0;
      evt[1]:  sel = 2'd1;
      evt[2]:  sel = 2'd2;
      evt[3]:  sel = 2'd3;
      default: sel = 2'd0;
    endcase
  end

  logic [1:0]  mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          full;
  logic          pop;
  logic          wr_en;

  assign full      = (count == FULL);
  assign key_valid = (count != '0);
  assign key_code  = mem[rd_ptr];
  assign pop       = key_valid & key_ready;
  // A pop on the same edge frees the slot a full queue needs.
  assign wr_en     = push & (~full | pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < FIFO_DEPTH; k++) mem[k] <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      dropped <= 1'b0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= sel;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      unique case ({wr_en, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
      dropped <= multi | (push & ~wr_en);
    end
  end

endmodule

// File: tb/tb_keypad_encoder.sv
// Bench for keypad_encoder: vector table, corner sequences and random
// stimulus against a queue-based reference model.
module tb_keypad_encoder;

  localparam int D = 20;
  localparam int N = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] key_raw;
  logic [3:0] key_held;
  logic [1:0] key_code;
  logic       key_valid;
  logic       key_ready;
  logic       dropped;

  keypad_encoder #(.DEBOUNCE_CYCLES(D), .FIFO_DEPTH(N)) dut (
    .clk(clk), .reset(reset), .key_raw(key_raw), .key_held(key_held),
    .key_code(key_code), .key_valid(key_valid), .key_ready(key_ready),
    .dropped(dropped)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int xfers = 0;
  int drops = 0;
  int got[$];

  bit [3:0] m_s1, m_s2, m_held, m_evt;
  bit       m_drop;
  int       mq[$];
  bit       hist[4][$];

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_s1 = 0; m_s2 = 0; m_held = 0; m_evt = 0; m_drop = 0;
    mq.delete();
    for (int i = 0; i < 4; i++) hist[i].delete();
  endtask

  // Reference: level flips once the last D+1 synchronised samples all
  // disagree with it; presses go through an N-entry queue.
  task automatic model_step();
    bit       pop;
    bit       nd;
    bit       diff;
    bit [3:0] nevt;
    int       code;
    if (reset) begin
      model_clear();
      return;
    end
    nd  = 0;
    pop = (mq.size() > 0) && key_ready;
    if (pop) void'(mq.pop_front());
    if (m_evt != 0) begin
      code = 0;
      while (!m_evt[code]) code++;
      if ($countones(m_evt) > 1) nd = 1;
      if (mq.size() < N) mq.push_back(code);
      else nd = 1;
    end
    nevt = 0;
    for (int i = 0; i < 4; i++) begin
      hist[i].push_back(m_s2[i]);
      if (hist[i].size() > D + 1) void'(hist[i].pop_front());
      diff = (hist[i].size() == D + 1);
      foreach (hist[i][k]) if (hist[i][k] == m_held[i]) diff = 0;
      if (diff) begin
        m_held[i] = ~m_held[i];
        nevt[i]   = m_held[i];
      end
    end
    m_evt  = nevt;
    m_drop = nd;
    m_s2   = m_s1;
    m_s1   = key_raw;
  endtask

  task automatic check_cycle();
    chk("held", key_held, m_held);
    chk("valid", key_valid, mq.size() > 0);
    if (key_valid === 1'b1 && mq.size() > 0) chk("code", key_code, mq[0]);
    chk("dropped", dropped, m_drop);
    if (dropped === 1'b1) drops++;
    if (key_valid === 1'b1 && key_ready === 1'b1) begin
      xfers++;
      got.push_back(int'(key_code));
    end
  endtask

  task automatic tick();
    @(negedge clk);
    check_cycle();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    key_raw   = 4'h0;
    key_ready = 1'b0;
    reset     = 1'b1;
    model_clear();
    repeat (3) tick();
    reset = 1'b0;
    tick();
    xfers = 0;
    drops = 0;
    got.delete();
  endtask

  task automatic press(input logic [3:0] k);
    key_raw = k;
    repeat (30) tick();
    key_raw = 4'h0;
    repeat (30) tick();
  endtask

  typedef struct {
    logic [3:0] raw;
    logic       rdy;
    int         cyc;
    logic [3:0] held;
    logic       valid;
    logic [1:0] code;
    int         drp;
    int         xf;
  } vec_t;

  vec_t tbl[13];
  int   exp_got[$];
  int   x0, d0;
  int   tm[4];

  initial begin
    reset     = 1'b1;
    key_raw   = 4'h0;
    key_ready = 1'b0;
    model_clear();
    repeat (3) tick();
    chk("rst_held", key_held, 0);
    chk("rst_valid", key_valid, 0);
    chk("rst_code", key_code, 0);
    chk("rst_dropped", dropped, 0);
    reset = 1'b0;
    tick();

    // Table: queue four presses, overflow, drain, then a collision.
    tbl[0]  = '{4'h0, 1'b0,  5, 4'h0, 1'b0, 2'd0, 0, 0};
    tbl[1]  = '{4'h1, 1'b0, 30, 4'h1, 1'b1, 2'd0, 0, 0};
    tbl[2]  = '{4'h0, 1'b0, 30, 4'h0, 1'b1, 2'd0, 0, 0};
    tbl[3]  = '{4'h2, 1'b0, 30, 4'h2, 1'b1, 2'd0, 0, 0};
    tbl[4]  = '{4'h0, 1'b0, 30, 4'h0, 1'b1, 2'd0, 0, 0};
    tbl[5]  = '{4'h4, 1'b0, 30, 4'h4, 1'b1, 2'd0, 0, 0};
    tbl[6]  = '{4'h0, 1'b0, 30, 4'h0, 1'b1, 2'd0, 0, 0};
    tbl[7]  = '{4'h8, 1'b0, 30, 4'h8, 1'b1, 2'd0, 0, 0};
    tbl[8]  = '{4'h0, 1'b0, 30, 4'h0, 1'b1, 2'd0, 0, 0};
    tbl[9]  = '{4'h1, 1'b0, 30, 4'h1, 1'b1, 2'd0, 1, 0};
    tbl[10] = '{4'h0, 1'b1, 30, 4'h0, 1'b0, 2'd0, 0, 4};
    tbl[11] = '{4'hA, 1'b0, 30, 4'hA, 1'b1, 2'd1, 1, 0};
    tbl[12] = '{4'h0, 1'b1, 30, 4'h0, 1'b0, 2'd0, 0, 1};
    got.delete();
    foreach (tbl[v]) begin
      key_raw   = tbl[v].raw;
      key_ready = tbl[v].rdy;
      x0 = xfers;
      d0 = drops;
      repeat (tbl[v].cyc) tick();
      chk($sformatf("tbl%0d_held", v), key_held, tbl[v].held);
      chk($sformatf("tbl%0d_valid", v), key_valid, tbl[v].valid);
      if (tbl[v].valid) chk($sformatf("tbl%0d_code", v), key_code, tbl[v].code);
      chk($sformatf("tbl%0d_drops", v), drops - d0, tbl[v].drp);
      chk($sformatf("tbl%0d_xfers", v), xfers - x0, tbl[v].xf);
    end
    exp_got = '{0, 1, 2, 3, 1};
    chk("tbl_order_len", got.size(), exp_got.size());
    foreach (exp_got[k]) if (k < got.size()) chk("tbl_order", got[k], exp_got[k]);

    // Latency of a single press with ready held high.
    do_reset();
    key_ready = 1'b1;
    key_raw   = 4'h4;
    repeat (22) tick();
    chk("lat_held_e21", key_held, 4'h0);
    tick();
    chk("lat_held_e22", key_held, 4'h4);
    chk("lat_valid_e22", key_valid, 0);
    tick();
    chk("lat_valid_e23", key_valid, 1);
    chk("lat_code_e23", key_code, 2);
    tick();
    chk("lat_valid_e24", key_valid, 0);
    repeat (20) tick();
    chk("lat_xfers", xfers, 1);
    chk("lat_got", got.size() > 0 ? got[0] : -1, 2);

    // Bounce shorter than the debounce window, then a clean press.
    do_reset();
    key_ready = 1'b1;
    for (int t = 0; t < 12; t++) begin
      key_raw[0] = ~key_raw[0];
      repeat (5) tick();
    end
    chk("bounce_xfers", xfers, 0);
    chk("bounce_held", key_held, 0);
    key_raw = 4'h1;
    repeat (40) tick();
    chk("bounce_after_xfers", xfers, 1);
    chk("bounce_after_code", got.size() > 0 ? got[0] : -1, 0);

    // Full queue: pop and push on the same edge.
    do_reset();
    press(4'h1);
    press(4'h2);
    press(4'h4);
    press(4'h8);
    chk("full_valid", key_valid, 1);
    key_raw = 4'h1;
    repeat (23) tick();
    key_ready = 1'b1;
    tick();
    key_ready = 1'b0;
    chk("full_pp_dropped", dropped, 0);
    chk("full_pp_code", key_code, 1);
    repeat (10) tick();
    key_raw   = 4'h0;
    key_ready = 1'b1;
    repeat (10) tick();
    exp_got = '{0, 1, 2, 3, 0};
    chk("full_pp_drops", drops, 0);
    chk("full_pp_len", got.size(), exp_got.size());
    foreach (exp_got[k]) if (k < got.size()) chk("full_pp_order", got[k], exp_got[k]);

    // Reset with codes queued and a key held.
    do_reset();
    press(4'h1);
    press(4'h2);
    key_raw = 4'h4;
    repeat (30) tick();
    chk("rq_valid_before", key_valid, 1);
    chk("rq_held_before", key_held, 4'h4);
    reset = 1'b1;
    model_clear();
    #2;
    chk("rq_valid_now", key_valid, 0);
    chk("rq_held_now", key_held, 0);
    repeat (2) tick();
    reset     = 1'b0;
    key_ready = 1'b1;
    xfers = 0;
    got.delete();
    repeat (40) tick();
    chk("rq_xfers", xfers, 1);
    chk("rq_code", got.size() > 0 ? got[0] : -1, 2);

    // Random presses, glitches and back-pressure.
    do_reset();
    foreach (tm[i]) tm[i] = $urandom_range(1, 45);
    for (int c = 0; c < 4000; c++) begin
      for (int i = 0; i < 4; i++) begin
        tm[i]--;
        if (tm[i] <= 0) begin
          key_raw[i] = ~key_raw[i];
          tm[i] = $urandom_range(1, 45);
        end
      end
      if ((c / 300) % 2 == 1) key_ready = 1'b0;
      else key_ready = ($urandom_range(0, 3) != 0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
